// File: rtl/hilo_divider_if.sv
// Handshake and result bus between the pipeline control and the HI/LO divider.
// The master side issues operations; the slave side (the divider) returns results.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, dataA, dataB,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, is_signed, dataA, dataB,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// remainder to HI and quotient to LO, with a sign fix-up cycle at the end.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  hilo_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] dividend_orig;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  // Magnitudes are only taken for DIV; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    abs_a     = (bus.is_signed && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
    abs_b     = (bus.is_signed && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
    rem_shift = {rem, quo[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dividend_orig <= '0;
      divisor       <= '0;
      quo           <= '0;
      rem           <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      zero_div      <= 1'b0;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.div_zero  <= 1'b0;
      bus.hi        <= '0;
      bus.lo        <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dividend_orig <= bus.dataA;
            divisor       <= abs_b;
            quo           <= abs_a;
            rem           <= '0;
            count         <= '0;
            sign_q        <= bus.is_signed & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
            sign_r        <= bus.is_signed & bus.dataA[WIDTH-1];
            zero_div      <= (bus.dataB == '0);
            bus.busy      <= 1'b1;
            state         <= (bus.dataB == '0) ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // The shifted remainder is always below twice the divisor, so the
          // truncated difference is exact.
          if (rem_ge) begin
            rem <= rem_shift[WIDTH-1:0] - divisor;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_div) begin
            bus.lo       <= '1;
            bus.hi       <= dividend_orig;
            bus.div_zero <= 1'b1;
          end else begin
            bus.lo       <= sign_q ? -quo : quo;
            bus.hi       <= sign_r ? -rem : rem;
            bus.div_zero <= 1'b0;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
